// File: rtl/aemb_dwb_pkg.sv
// Shared definitions for the AEMB data-bus slave: FSM encoding and wait-counter width.
package aemb_dwb_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } dwbState_t;

endpackage

// File: rtl/aemb_spram.sv
// Single-port 32-bit RAM, four byte write enables, registered read, falling-edge clocked.
module aemb_spram #(
  parameter int AW = 10
) (
  input  logic          nclk,
  input  logic [AW-1:0] adr,
  input  logic [31:0]   wrDat,
  input  logic [3:0]    wrEn,
  output logic [31:0]   rdDat
);

  // NOTE: storage has no reset; clearing it would turn the array into flops instead of RAM.
  logic [31:0] mem [2**AW];

  always_ff @(negedge nclk) begin
    for (int b = 0; b < 4; b++) begin
      if (wrEn[b]) mem[adr][8*b +: 8] <= wrDat[8*b +: 8];
    end
    rdDat <= mem[adr];
  end

endmodule

// File: rtl/aemb_dwb_slave.sv
// AEMB data-bus slave: local RAM window at BASE, programmable wait states, ack on hit, err on miss.
module aemb_dwb_slave
  import aemb_dwb_pkg::*;
#(
  parameter int          DSIZ = 32,
  parameter int          AW   = 10,
  parameter logic [31:0] BASE = 32'h0000_0000,
  parameter int          WAIT = 0
) (
  input  logic            nclk,
  input  logic            nrst,
  input  logic [DSIZ-1:0] dwb_adr_i,
  input  logic [31:0]     dwb_dat_i,
  input  logic [3:0]      dwb_sel_i,
  input  logic            dwb_we_i,
  input  logic            dwb_stb_i,
  input  logic            dwb_cyc_i,
  output logic [31:0]     dwb_dat_o,
  output logic            dwb_ack_o,
  output logic            dwb_err_o
);

  localparam logic [CNT_W-1:0] WAIT_LOAD = (WAIT > 0) ? CNT_W'(WAIT - 1) : '0;

  dwbState_t        state, nextState;
  logic [CNT_W-1:0] cnt, cntNext;

  logic [DSIZ-1:2]  adrQ;
  logic [31:0]      datQ;
  logic [3:0]       selQ;
  logic             weQ;

  logic [DSIZ-1:2]  reqAdr;
  logic [31:0]      reqDat;
  logic [3:0]       reqSel;
  logic             reqWe;
  logic             reqHit;
  logic             req;
  logic             enterAck;
  logic [3:0]       ramBe;
  logic [31:0]      ramDat;

  // Byte offset within a word plays no part in decode.
  logic unusedAdr;
  assign unusedAdr = &{1'b0, dwb_adr_i[1:0]};

  assign req = dwb_cyc_i & dwb_stb_i;

  // With no wait states the RAM is written/read on the accept edge itself, so IDLE uses live inputs.
  assign reqAdr = (state == ST_IDLE) ? dwb_adr_i[DSIZ-1:2] : adrQ;
  assign reqDat = (state == ST_IDLE) ? dwb_dat_i : datQ;
  assign reqSel = (state == ST_IDLE) ? dwb_sel_i : selQ;
  assign reqWe  = (state == ST_IDLE) ? dwb_we_i  : weQ;
  assign reqHit = (reqAdr[DSIZ-1:AW+2] == BASE[DSIZ-1:AW+2]);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    nextState = state;
    cntNext   = cnt;
    case (state)
      ST_IDLE: begin
        if (req) begin
          if (WAIT == 0) begin
            nextState = ST_ACK;
          end else begin
            nextState = ST_WAIT;
            cntNext   = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (!req) begin
          nextState = ST_IDLE;
          cntNext   = '0;
        end else if (cnt == '0) begin
          nextState = ST_ACK;
        end else begin
          cntNext = cnt - 1'b1;
        end
      end
      ST_ACK:  nextState = ST_IDLE;
      default: nextState = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(negedge nclk) begin
    if (nrst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= nextState;
      cnt   <= cntNext;
    end
  end

  always_ff @(negedge nclk) begin
    if (state == ST_IDLE && req) begin
      adrQ <= dwb_adr_i[DSIZ-1:2];
      datQ <= dwb_dat_i;
      selQ <= dwb_sel_i;
      weQ  <= dwb_we_i;
    end
  end

  // Write commits only on the edge entering ACK; aborts and resets before then drop it.
  assign enterAck = (nextState == ST_ACK) && !nrst;
  assign ramBe    = (enterAck && reqHit && reqWe) ? reqSel : 4'b0000;

  aemb_spram #(
    .AW(AW)
  ) u_spram (
    .nclk (nclk),
    .adr  (reqAdr[AW+1:2]),
    .wrDat(reqDat),
    .wrEn (ramBe),
    .rdDat(ramDat)
  );

  assign dwb_ack_o = (state == ST_ACK) &&  reqHit;
  assign dwb_err_o = (state == ST_ACK) && !reqHit;
  assign dwb_dat_o = ((state == ST_ACK) && reqHit && !reqWe) ? ramDat : 32'h0;

endmodule

// File: tb/tb_aemb_dwb_slave.sv
// Directed bench: three slaves (WAIT = 0, 3, 5) sharing a bus, each selected by its own cyc/stb.
module tb_aemb_dwb_slave;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        nclk = 1'b0;
  logic        nrst = 1'b1;
  logic [31:0] adr  = '0;
  logic [31:0] wdat = '0;
  logic [3:0]  sel  = '0;
  logic        we   = 1'b0;
  logic [2:0]  cyc  = '0;
  logic [2:0]  stb  = '0;
  logic [2:0]  ackO;
  logic [2:0]  errO;
  logic [31:0] datO [3];

  int nTests = 0;
  int nFail  = 0;

  always #5 nclk = ~nclk;

  aemb_dwb_slave #(.DSIZ(32), .AW(10), .BASE(BASE), .WAIT(0)) u0 (
    .nclk(nclk), .nrst(nrst), .dwb_adr_i(adr), .dwb_dat_i(wdat), .dwb_sel_i(sel),
    .dwb_we_i(we), .dwb_stb_i(stb[0]), .dwb_cyc_i(cyc[0]),
    .dwb_dat_o(datO[0]), .dwb_ack_o(ackO[0]), .dwb_err_o(errO[0]));

  aemb_dwb_slave #(.DSIZ(32), .AW(10), .BASE(BASE), .WAIT(3)) u3 (
    .nclk(nclk), .nrst(nrst), .dwb_adr_i(adr), .dwb_dat_i(wdat), .dwb_sel_i(sel),
    .dwb_we_i(we), .dwb_stb_i(stb[1]), .dwb_cyc_i(cyc[1]),
    .dwb_dat_o(datO[1]), .dwb_ack_o(ackO[1]), .dwb_err_o(errO[1]));

  aemb_dwb_slave #(.DSIZ(32), .AW(10), .BASE(BASE), .WAIT(5)) u5 (
    .nclk(nclk), .nrst(nrst), .dwb_adr_i(adr), .dwb_dat_i(wdat), .dwb_sel_i(sel),
    .dwb_we_i(we), .dwb_stb_i(stb[2]), .dwb_cyc_i(cyc[2]),
    .dwb_dat_o(datO[2]), .dwb_ack_o(ackO[2]), .dwb_err_o(errO[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One transfer: accept on the next falling edge, then watch 16 cycles at the rising edge.
  // lat = rising edges after accept until termination seen (-1 if none).
  task automatic xfer(input int idx, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output int lat, output int ackN, output int errN,
                      output logic [31:0] rd, output logic [31:0] other);
    @(posedge nclk); #1;
    adr = a; wdat = d; sel = s; we = w;
    cyc[idx] = 1'b1; stb[idx] = 1'b1;
    lat = -1; ackN = 0; errN = 0; rd = '0; other = '0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge nclk);
      if (ackO[idx] || errO[idx]) begin
        if (lat < 0) begin
          lat = k;
          rd  = datO[idx];
        end
        ackN += int'(ackO[idx]);
        errN += int'(errO[idx]);
        #1 cyc[idx] = 1'b0; stb[idx] = 1'b0;
      end else begin
        other |= datO[idx];
      end
    end
    cyc[idx] = 1'b0; stb[idx] = 1'b0;
  endtask

  task automatic wr(input int idx, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int l, an, en;
    logic [31:0] r, o;
    xfer(idx, 1'b1, a, d, s, l, an, en, r, o);
  endtask

  task automatic rdChk(input string tag, input int idx, input logic [31:0] a, input logic [31:0] exp);
    int l, an, en;
    logic [31:0] r, o;
    xfer(idx, 1'b0, a, '0, 4'hF, l, an, en, r, o);
    check(tag, r, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, ackN, errN;
    logic [31:0] rd, other;

    // Reset
    repeat (3) @(negedge nclk);
    @(posedge nclk);
    for (int i = 0; i < 3; i++)
      check($sformatf("reset_out%0d", i), {ackO[i], errO[i], datO[i]}, 34'h0);
    #1 nrst = 1'b0;

    // WAIT=0 write then read
    xfer(0, 1'b1, BASE + 32'h10, 32'hDEADBEEF, 4'hF, lat, ackN, errN, rd, other);
    check("w0_wr_lat", 32'(lat), 32'd1);
    check("w0_wr_ackN", 32'(ackN), 32'd1);
    check("w0_wr_errN", 32'(errN), 32'd0);
    xfer(0, 1'b0, BASE + 32'h10, 32'h0, 4'hF, lat, ackN, errN, rd, other);
    check("w0_rd_lat", 32'(lat), 32'd1);
    check("w0_rd_ackN", 32'(ackN), 32'd1);
    check("w0_rd_data", rd, 32'hDEADBEEF);
    check("w0_rd_dat_idle", other, 32'h0);
    rdChk("w0_rd_lowbits", 0, BASE + 32'h13, 32'hDEADBEEF);

    // Byte lanes (big-endian: sel[3] = bits 31:24)
    wr(0, BASE + 32'h20, 32'h11223344, 4'hF);
    wr(0, BASE + 32'h20, 32'h000000AA, 4'b0001);
    rdChk("lane_sel0001", 0, BASE + 32'h20, 32'h112233AA);
    xfer(0, 1'b1, BASE + 32'h20, 32'hFFFFFFFF, 4'b0000, lat, ackN, errN, rd, other);
    check("sel0000_ack", 32'(ackN), 32'd1);
    rdChk("sel0000_nochange", 0, BASE + 32'h20, 32'h112233AA);
    wr(0, BASE + 32'h20, 32'hAB000000, 4'b1000);
    rdChk("lane_sel1000", 0, BASE + 32'h20, 32'hAB2233AA);

    // Misses just above and below the window
    xfer(0, 1'b1, BASE + 32'h1000 + 32'h10, 32'h55555555, 4'hF, lat, ackN, errN, rd, other);
    check("miss_wr_lat", 32'(lat), 32'd1);
    check("miss_wr_errN", 32'(errN), 32'd1);
    check("miss_wr_ackN", 32'(ackN), 32'd0);
    xfer(0, 1'b0, BASE - 32'h1000 + 32'h10, 32'h0, 4'hF, lat, ackN, errN, rd, other);
    check("miss_rd_errN", 32'(errN), 32'd1);
    check("miss_rd_ackN", 32'(ackN), 32'd0);
    check("miss_rd_dat", rd | other, 32'h0);
    rdChk("miss_mem_unchanged", 0, BASE + 32'h10, 32'hDEADBEEF);

    // WAIT=3 latency
    wr(1, BASE + 32'h04, 32'hCAFEF00D, 4'hF);
    wr(1, BASE + 32'h08, 32'h0BADF00D, 4'hF);
    xfer(1, 1'b0, BASE + 32'h04, 32'h0, 4'hF, lat, ackN, errN, rd, other);
    check("w3_rd_lat", 32'(lat), 32'd4);
    check("w3_rd_ackN", 32'(ackN), 32'd1);
    check("w3_rd_errN", 32'(errN), 32'd0);
    check("w3_rd_data", rd, 32'hCAFEF00D);
    check("w3_rd_dat_idle", other, 32'h0);

    // Reset mid-WAIT of a write: request held high through the reset edge
    @(posedge nclk); #1;
    adr = BASE + 32'h04; wdat = 32'h12345678; sel = 4'hF; we = 1'b1;
    cyc[1] = 1'b1; stb[1] = 1'b1;
    @(negedge nclk);
    @(posedge nclk); #1 nrst = 1'b1;
    @(negedge nclk);
    @(posedge nclk);
    check("rst_mid_out", {ackO[1], errO[1], datO[1]}, 34'h0);
    check("rst_mid_state", 32'(u3.state), 32'd0);
    check("rst_mid_cnt", 32'(u3.cnt), 32'd0);
    #1 nrst = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0;
    ackN = 0;
    repeat (8) begin
      @(posedge nclk);
      ackN += int'(ackO[1] | errO[1]);
    end
    check("rst_mid_noterm", 32'(ackN), 32'd0);
    rdChk("rst_word_kept", 1, BASE + 32'h04, 32'hCAFEF00D);
    rdChk("rst_other_kept", 1, BASE + 32'h08, 32'h0BADF00D);

    // WAIT=5: abort by dropping stb two cycles after accept
    wr(2, BASE + 32'h30, 32'h01020304, 4'hF);
    @(posedge nclk); #1;
    adr = BASE + 32'h30; wdat = 32'hFFFFFFFF; sel = 4'hF; we = 1'b1;
    cyc[2] = 1'b1; stb[2] = 1'b1;
    @(negedge nclk);
    @(posedge nclk);
    @(negedge nclk);
    @(posedge nclk); #1 stb[2] = 1'b0;
    ackN = 0;
    repeat (12) begin
      @(posedge nclk);
      ackN += int'(ackO[2] | errO[2]);
    end
    cyc[2] = 1'b0;
    check("abort_noterm", 32'(ackN), 32'd0);
    xfer(2, 1'b0, BASE + 32'h30, 32'h0, 4'hF, lat, ackN, errN, rd, other);
    check("abort_next_lat", 32'(lat), 32'd6);
    check("abort_next_ackN", 32'(ackN), 32'd1);
    check("abort_word_kept", rd, 32'h01020304);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/aemb_dwb_slave.md
AEMB_DWB_SLAVE -- requirements
Module: aemb_dwb_slave

Interface
REQ-001 SHALL have parameter DSIZ, default 32: data-bus address width.
REQ-002 SHALL have parameter AW, default 10: word-address bits of local memory (2^AW x 32-bit words).
REQ-003 SHALL have parameter BASE, default 32'h0000_0000: base address, aligned to 2^(AW+2) bytes.
REQ-004 SHALL have parameter WAIT, default 0, range 0..15: wait states inserted before acknowledge.
REQ-005 SHALL have port nclk, input, 1: single clock; all flops update on falling edge, matching core timing.
REQ-006 SHALL have port nrst, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port dwb_adr_i, input, DSIZ: byte address from core.
REQ-008 SHALL have port dwb_dat_i, input, 32: write data, big-endian byte order.
REQ-009 SHALL have port dwb_sel_i, input, 4: byte lane enables; bit 3 = bits 31:24 = byte offset 0.
REQ-010 SHALL have port dwb_we_i, input, 1: 1 write, 0 read.
REQ-011 SHALL have port dwb_stb_i, input, 1: strobe.
REQ-012 SHALL have port dwb_cyc_i, input, 1: bus cycle valid.
REQ-013 SHALL have port dwb_dat_o, output, 32: read data, big-endian byte order.
REQ-014 SHALL have port dwb_ack_o, output, 1: transfer complete.
REQ-015 SHALL have port dwb_err_o, output, 1: address-miss termination.

Function
REQ-016 SHALL accept a request at an edge where state is IDLE and dwb_cyc_i & dwb_stb_i = 1; it SHALL latch adr, we, sel, dat at that edge.
REQ-017 SHALL decode hit = (latched adr[DSIZ-1:AW+2] == BASE[DSIZ-1:AW+2]); word index = adr[AW+1:2]; adr[1:0] ignored.
REQ-018 SHALL implement FSM IDLE, WAIT, ACK: IDLE->ACK on accept when WAIT=0; IDLE->WAIT on accept when WAIT>0, loading a 4-bit counter with WAIT-1; WAIT decrements each cycle and ->ACK at count 0; ACK->IDLE unconditionally.
REQ-019 SHALL assert exactly one of dwb_ack_o (hit) or dwb_err_o (miss) for exactly one cycle, in ACK state only; latency accept-edge to termination = WAIT+1 cycles.
REQ-020 SHALL not accept a new request in ACK state (turnaround cycle); peak throughput 1 transfer per WAIT+2 cycles.
REQ-021 SHALL, on hit write, update only lanes whose latched sel bit is set, at the edge entering ACK; sel=4'b0000 still acknowledges with no change.
REQ-022 SHALL, on hit read, present the addressed word on dwb_dat_o during the ACK cycle; dwb_dat_o = 0 in all other cycles and on miss.
REQ-023 SHALL, on miss, perform no memory write and assert dwb_err_o.
REQ-024 SHALL abort when dwb_cyc_i or dwb_stb_i is 0 at any edge in WAIT: return to IDLE, no ack/err, no write.
REQ-025 SHALL not abort once in ACK state; input changes in ACK have no effect.
REQ-026 SHALL make read-after-write to the same word on consecutive transfers return the written data.

Reset
REQ-027 SHALL, with nrst=1 at an edge, force state IDLE, counter 0, dwb_ack_o=0, dwb_err_o=0, dwb_dat_o=0, including mid-WAIT or in ACK; the pending write SHALL be dropped.
REQ-028 SHALL not initialise memory contents on reset.

Structure
REQ-029 SHALL place FSM state encoding (IDLE=2'd0, WAIT=2'd1, ACK=2'd2) and counter width constant in shared package aemb_dwb_pkg.
REQ-030 SHALL instantiate one sub-module aemb_spram: single-port 2^AW x 32 synchronous RAM with 4 byte write enables and registered read.

Verification
REQ-031 WAIT=0: write 32'hDEADBEEF sel=4'hF to BASE+0x10, then read BASE+0x10 -> ack 1 cycle after each accept, read data 32'hDEADBEEF.
REQ-032 WAIT=3: read BASE+0x4 -> ack asserted exactly 4 cycles after accept, one cycle wide.
REQ-033 Byte write 32'h000000AA sel=4'b0001 to word holding 32'h11223344 -> subsequent read 32'h112233AA.
REQ-034 Access BASE+2^(AW+2) -> dwb_err_o 1 cycle, ack 0, dwb_dat_o 0, memory unchanged.
REQ-035 WAIT=5: write accepted, stb dropped after 2 cycles -> no ack/err, target word unchanged; next request accepted normally.
REQ-036 nrst pulsed while in WAIT of a write -> outputs 0 next cycle, FSM IDLE, word unchanged, prior contents intact.
